// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and helpers for the FIR requantiser.
//   calc_in_width      - accumulator width from data and coefficient widths
//   fill_beats_default - upstream pipeline fill depth from the multiplier count
//   sat_max / sat_min  - output clamp limits for a given output width
// Macro CONV_REQUANT_SYM_SAT_EN: when defined, sat_min is -(2^(w-1)-1),
// which gives a symmetric output range.
package conv_pkg;

    function automatic int unsigned calc_in_width(int unsigned data_w, int unsigned coef_w);
        return data_w + coef_w + 4;
    endfunction

    function automatic int unsigned fill_beats_default(int unsigned mult_num);
        return 5 + $clog2(mult_num);
    endfunction

    localparam int unsigned DEF_MULT_NUM   = 32;
    localparam int unsigned DEF_FILL_BEATS = fill_beats_default(DEF_MULT_NUM);
    localparam int unsigned DEF_IN_WIDTH   = calc_in_width(16, 16);

    function automatic longint sat_max(int unsigned out_w);
        return (longint'(1) <<< (out_w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(int unsigned out_w);
`ifdef CONV_REQUANT_SYM_SAT_EN
        return -sat_max(out_w);
`else
        return -(longint'(1) <<< (out_w - 1));
`endif
    endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane: one phase of the requantiser.
//   Input register -> round-half-up arithmetic shift -> clamp into o_y.
//   Every register advances only when i_vld is high.
// Ports: clk, reset (async, active-high), i_vld, i_x (signed word),
//        i_shift (shift amount), o_y (registered sample),
//        o_sat_c (the clamp taken by the next i_vld beat; combinational).
module requant_lane
    import conv_pkg::*;
#(
    parameter int unsigned IN_W    = 36,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_vld,
    input  logic [IN_W-1:0]    i_x,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [OUT_W-1:0]   o_y,
    output logic               o_sat_c
);

    localparam int unsigned          SH_MAX = IN_W - 1;
    localparam logic signed [IN_W:0] MAX_V  = (IN_W+1)'(sat_max(OUT_W));
    localparam logic signed [IN_W:0] MIN_V  = (IN_W+1)'(sat_min(OUT_W));

    logic signed [IN_W-1:0] x_q, x_d;
    logic [SHIFT_W-1:0]     sh_q, sh_d;
    logic signed [IN_W:0]   r_q, r_d;
    logic [OUT_W-1:0]       y_q, y_d;
    logic signed [IN_W:0]   rnd_c, sum_c;
    logic [OUT_W-1:0]       y_sat_c;
    int unsigned            sh_c;

    // Rounding shift on the registered word, then clamp of the shifted value.
    always_comb begin
        x_d     = x_q;
        sh_d    = sh_q;
        r_d     = r_q;
        y_d     = y_q;
        o_sat_c = 1'b0;
        y_sat_c = r_q[OUT_W-1:0];

        sh_c  = (32'(sh_q) > SH_MAX) ? SH_MAX : 32'(sh_q);
        rnd_c = '0;
        if (sh_c != 0) begin
            rnd_c = (IN_W+1)'(1) << (sh_c - 1);
        end
        // One guard bit keeps the rounding add from wrapping.
        sum_c = {x_q[IN_W-1], x_q} + rnd_c;

        if (r_q > MAX_V) begin
            y_sat_c = MAX_V[OUT_W-1:0];
            o_sat_c = 1'b1;
        end else if (r_q < MIN_V) begin
            y_sat_c = MIN_V[OUT_W-1:0];
            o_sat_c = 1'b1;
        end

        if (i_vld) begin
            x_d  = i_x;
            sh_d = i_shift;
            r_d  = sum_c >>> sh_c;
            y_d  = y_sat_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q  <= '0;
            sh_q <= '0;
            r_q  <= '0;
            y_q  <= '0;
        end else begin
            x_q  <= x_d;
            sh_q <= sh_d;
            r_q  <= r_d;
            y_q  <= y_d;
        end
    end

    assign o_y = y_q;

endmodule

// File: rtl/conv_requant.sv
// conv_requant: requantises the polyphase FIR accumulator words to output samples.
//   Each phase uses a round-half-up right shift followed by a clamp.
//   o_vldout is suppressed until the upstream pipeline has filled.
//   Saturation is reported through a sticky flag and a beat counter.
// Ports: clk, reset (async, active-high), i_dtin / o_dout (phase-packed buses),
//        i_vldin, i_shift, i_flush, i_sat_clr, o_vldout, o_sat_sticky, o_sat_cnt.
// Macro CONV_REQUANT_SYM_SAT_EN: selects a symmetric clamp range.
module conv_requant
    import conv_pkg::*;
#(
    parameter int unsigned _IN_WIDTH    = DEF_IN_WIDTH,
    parameter int unsigned _OUT_WIDTH   = 16,
    parameter int unsigned _PHASE_NUM   = 1,
    parameter int unsigned _SHIFT_WIDTH = 6,
    parameter int unsigned _FILL_BEATS  = DEF_FILL_BEATS,
    parameter int unsigned _CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [_IN_WIDTH*_PHASE_NUM-1:0]  i_dtin,
    input  logic                            i_vldin,
    input  logic [_SHIFT_WIDTH-1:0]          i_shift,
    input  logic                            i_flush,
    input  logic                            i_sat_clr,
    output logic [_OUT_WIDTH*_PHASE_NUM-1:0] o_dout,
    output logic                            o_vldout,
    output logic                            o_sat_sticky,
    output logic [_CNT_WIDTH-1:0]            o_sat_cnt
);

    localparam int unsigned CW = _CNT_WIDTH;
    localparam int unsigned FW = $clog2(_FILL_BEATS + 3);
    // The counter saturates here: the fill beats plus the two data stages.
    localparam logic [FW-1:0] FILL_DONE = FW'(_FILL_BEATS + 2);

    logic [_PHASE_NUM-1:0] sat_vec_c;
    logic [FW-1:0]         fill_q, fill_d;
    logic                  vld_q, vld_d;
    logic                  sticky_q, sticky_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sat_ev_c;

    // One lane per phase.
    for (genvar k = 0; k < _PHASE_NUM; k++) begin : g_lane
        requant_lane #(
            .IN_W    (_IN_WIDTH),
            .OUT_W   (_OUT_WIDTH),
            .SHIFT_W (_SHIFT_WIDTH)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .i_vld   (i_vldin),
            .i_x     (i_dtin[_IN_WIDTH*k +: _IN_WIDTH]),
            .i_shift (i_shift),
            .o_y     (o_dout[_OUT_WIDTH*k +: _OUT_WIDTH]),
            .o_sat_c (sat_vec_c[k])
        );
    end

    // Fill tracking and saturation statistics.
    always_comb begin
        fill_d   = fill_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        // vld_d sees the counter before this edge's increment; flush overrides.
        vld_d = i_vldin && !i_flush && (fill_q == FILL_DONE);
        if (i_flush) begin
            fill_d = '0;
        end else if (i_vldin && (fill_q != FILL_DONE)) begin
            fill_d = fill_q + FW'(1);
        end

        sat_ev_c = i_vldin && (|sat_vec_c);
        // A clear in the same cycle still keeps this beat's event.
        if (i_sat_clr) begin
            sticky_d = sat_ev_c;
            cnt_d    = sat_ev_c ? CW'(1) : '0;
        end else if (sat_ev_c) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q   <= '0;
            vld_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            fill_q   <= fill_d;
            vld_q    <= vld_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_vldout     = vld_q;
    assign o_sat_sticky = sticky_q;
    assign o_sat_cnt    = cnt_q;

endmodule
